instr_fetch: RTL

- Consumer end of the program-counter interface. Takes the PC address, issues it to a synchronous instruction ROM, and buffers the returned instruction/address pairs in a small FIFO for the decode stage.
- The PC increments every cycle with no enable, so this block controls the PC through its load/data pins:
  - Holds the PC by reloading its current value when the FIFO has no room.
  - Steers the PC to a new address on a redirect (branch/jump).

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instr_fetch.sv | 101 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and types for the instruction-fetch slice.
// Holds the default widths/depth, the FIFO entry layout and the count-width helper.
package fetch_pkg;

    localparam int unsigned AW_DEF    = 4;
    localparam int unsigned IW_DEF    = 8;
    localparam int unsigned DEPTH_DEF = 4;

    // One buffered fetch result: the address it was read from and the word returned.
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [IW_DEF-1:0] instr;
    } fetch_entry_t;

    // Occupancy counters need one extra bit so that DEPTH itself is representable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous-write FIFO with storage-backed read port.
// Flush clears pointers and count in one cycle; DEPTH must be a power of two >= 2.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned W     = AW_DEF + IW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Qualify requests so a stray pop on empty or push on full cannot corrupt state.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the read port shows zero until first write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: issues the PC to a synchronous ROM and buffers results for decode.
// The PC free-runs, so this block holds it (reload current value) when there is no
// room and steers it on redirect. Optional macro FETCH_BYPASS_EN forwards the ROM
// response straight to decode when the FIFO is empty (1-cycle issue-to-valid).
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned IW    = IW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_addr,
    output logic          pc_load,
    output logic [AW-1:0] pc_data,
    output logic [AW-1:0] imem_addr,
    output logic          imem_en,
    input  logic [IW-1:0] imem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_addr,
    output logic          fd_valid,
    input  logic          fd_ready,
    output logic [IW-1:0] fd_instr,
    output logic [AW-1:0] fd_pc
);

    localparam int unsigned CW = cnt_width(DEPTH);

    logic              inflight_v;
    logic [AW-1:0]     inflight_addr;
    logic [CW-1:0]     count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [AW+IW-1:0]  fifo_din;
    logic [AW+IW-1:0]  fifo_dout;
    logic [CW:0]       occupancy;
    logic              issue;
    logic              bypass;
    logic              push;
    logic              pop;

    // Issue only when every outstanding fetch is guaranteed a FIFO slot.
    always_comb begin
        occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_v};
        issue     = rst_n && !redirect_valid && !fifo_full
                    && (occupancy < (CW+1)'(DEPTH));
        imem_addr = pc_addr;
        imem_en   = issue;
        // Not issuing means the PC must not advance: reload it (hold) or steer it.
        pc_load   = rst_n && !issue;
        pc_data   = redirect_valid ? redirect_addr : pc_addr;
    end

    // Decode-side mux: FIFO head, or the live ROM response when bypass applies.
    always_comb begin
`ifdef FETCH_BYPASS_EN
        bypass = fifo_empty && inflight_v;
`else
        bypass = 1'b0;
`endif
        fd_valid = !fifo_empty || bypass;
        fd_instr = bypass ? imem_rdata    : fifo_dout[IW-1:0];
        fd_pc    = bypass ? inflight_addr : fifo_dout[AW+IW-1:IW];
        pop      = !fifo_empty && fd_ready;
        // A bypassed word that decode takes is consumed here and never stored;
        // a redirect discards whatever response is arriving this cycle.
        push     = inflight_v && !redirect_valid && !(bypass && fd_ready);
        fifo_din = {inflight_addr, imem_rdata};
    end

    // In-flight tracker: remembers the address of the word the ROM returns next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_v    <= 1'b0;
            inflight_addr <= '0;
        end else if (issue) begin
            inflight_v    <= 1'b1;
            inflight_addr <= pc_addr;
        end else begin
            inflight_v    <= 1'b0;
        end
    end

    fetch_fifo #(
        .W     (AW + IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule
